// File: rtl/mux_serializer_32bit_pkg.sv
// mux_serializer_32bit_pkg
//   Shared constants, FSM state encoding and a helper for the 32-bit PISO
//   serializer. The optional parity bit is controlled by the PARITY_EN macro.
//   S_PARITY is always encoded so that the state width and encoding are the
//   same in both builds.
package mux_serializer_32bit_pkg;

    localparam int DATA_BITS = 32;
    localparam int SEL_W     = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_e;

    // Select index of the first bit of a frame.
    function automatic logic [SEL_W-1:0] start_idx(input bit msb_first);
        return msb_first ? SEL_W'(DATA_BITS - 1) : '0;
    endfunction

    // Select index of the last data bit of a frame.
    function automatic logic [SEL_W-1:0] end_idx(input bit msb_first);
        return msb_first ? '0 : SEL_W'(DATA_BITS - 1);
    endfunction

endpackage

// File: rtl/mux_serializer_32bit_if.sv
// mux_serializer_32bit_if
//   Load handshake and serial stream bundle for mux_serializer_32bit.
//   The master modport is the parallel-word source and stream consumer.
//   The slave modport is the serializer.
//     load_valid / load_ready / data_in : parallel word handshake
//     sel                               : current mux select index
//     ser_out / ser_valid / ser_last    : serial stream with its qualifiers
interface mux_serializer_32bit_if;
    import mux_serializer_32bit_pkg::*;

    logic                 load_valid;
    logic                 load_ready;
    logic [DATA_BITS-1:0] data_in;
    logic [SEL_W-1:0]     sel;
    logic                 ser_out;
    logic                 ser_valid;
    logic                 ser_last;

    modport master (
        output load_valid, data_in,
        input  load_ready, sel, ser_out, ser_valid, ser_last
    );

    modport slave (
        input  load_valid, data_in,
        output load_ready, sel, ser_out, ser_valid, ser_last
    );

endinterface

// File: rtl/mux_serializer_32bit_mux.sv
// mux_32x1frm16x1
//   A 32:1 single-bit mux built from two 16:1 halves and a final 2:1 stage.
//   The design is purely combinational.
//     in_i  [31:0] : data word
//     sel_i [4:0]  : bit index
//     out_o        : in_i[sel_i]
module mux_32x1frm16x1
    import mux_serializer_32bit_pkg::*;
(
    input  logic [DATA_BITS-1:0] in_i,
    input  logic [SEL_W-1:0]     sel_i,
    output logic                 out_o
);

    logic [15:0] lo_half;
    logic [15:0] hi_half;
    logic        lo_bit;
    logic        hi_bit;

    assign lo_half = in_i[15:0];
    assign hi_half = in_i[31:16];
    assign lo_bit  = lo_half[sel_i[3:0]];
    assign hi_bit  = hi_half[sel_i[3:0]];
    assign out_o   = sel_i[4] ? hi_bit : lo_bit;

endmodule

// File: rtl/mux_serializer_32bit.sv
// mux_serializer_32bit
//   This block accepts a 32-bit word over a valid/ready handshake and holds it.
//   It then sweeps the mux select across all 32 positions and emits one bit
//   per clock.
//   Define PARITY_EN to append an even-parity bit, giving a 33-clock frame.
//     clk, rst : rising-edge clock, asynchronous active-high reset
//     bus      : slave side of mux_serializer_32bit_if
//                (load_valid/load_ready/data_in in, sel/ser_out/ser_valid/ser_last out)
//   Parameters:
//     MSB_FIRST  : 0 sends bit 0 first, 1 sends bit 31 first
//     IDLE_LEVEL : value driven on ser_out while ser_valid is 0
module mux_serializer_32bit
    import mux_serializer_32bit_pkg::*;
#(
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_serializer_32bit_if.slave bus
);

    localparam logic [SEL_W-1:0] START = start_idx(MSB_FIRST);
    localparam logic [SEL_W-1:0] LAST  = end_idx(MSB_FIRST);

    state_e               state_q;
    logic [DATA_BITS-1:0] hold_q;
    logic [SEL_W-1:0]     sel_q;
    logic [SEL_W-1:0]     sel_d;
    logic                 at_end;
    logic                 load_ready;
    logic                 mux_bit;

    assign at_end = (state_q == S_SHIFT) && (sel_q == LAST);
    assign sel_d  = MSB_FIRST ? sel_q - 1'b1 : sel_q + 1'b1;

`ifdef PARITY_EN
    // The parity slot takes the place of the data end index as the load point.
    assign load_ready = (state_q != S_SHIFT);
`else
    assign load_ready = (state_q == S_IDLE) || at_end;
`endif

    mux_32x1frm16x1 u_mux (
        .in_i  (hold_q),
        .sel_i (sel_q),
        .out_o (mux_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            sel_q   <= START;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sel_q <= START;
                    if (bus.load_valid) begin
                        hold_q  <= bus.data_in;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!at_end) begin
                        sel_q <= sel_d;
                    end else begin
`ifdef PARITY_EN
                        // sel stays on the end index during the parity slot.
                        state_q <= S_PARITY;
`else
                        sel_q <= START;
                        if (bus.load_valid) hold_q <= bus.data_in;
                        else                state_q <= S_IDLE;
`endif
                    end
                end
                S_PARITY: begin
                    sel_q <= START;
                    if (bus.load_valid) begin
                        hold_q  <= bus.data_in;
                        state_q <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    sel_q   <= START;
                end
            endcase
        end
    end

    // The stream qualifiers are decoded from registered state only. ser_out
    // follows sel through the mux in the same cycle.
    always_comb begin
        bus.ser_out   = IDLE_LEVEL;
        bus.ser_valid = (state_q != S_IDLE);
        bus.ser_last  = 1'b0;
        case (state_q)
            S_SHIFT: begin
                bus.ser_out = mux_bit;
`ifndef PARITY_EN
                bus.ser_last = at_end;
`endif
            end
`ifdef PARITY_EN
            S_PARITY: begin
                bus.ser_out  = ^hold_q;
                bus.ser_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.load_ready = load_ready;
    assign bus.sel        = sel_q;

endmodule

// File: tb/tb_mux_serializer_32bit.sv
// tb_mux_serializer_32bit
//   Directed bench with two instances: u0 (LSB first, idle level 0) and
//   u1 (MSB first, idle level 1). A vector table drives single frames.
//   Hand-written sequences cover back-to-back loads, mid-frame reset and
//   data_in changes while busy.
module tb_mux_serializer_32bit;

    logic clk;
    logic rst;
    logic        lv  [2];
    logic [31:0] din [2];

    logic [4:0] o_sel [2];
    logic       o_out [2];
    logic       o_vld [2];
    logic       o_lst [2];
    logic       o_rdy [2];

    int checks = 0;
    int errors = 0;

    mux_serializer_32bit_if if0 ();
    mux_serializer_32bit_if if1 ();

    assign if0.load_valid = lv[0];
    assign if0.data_in    = din[0];
    assign if1.load_valid = lv[1];
    assign if1.data_in    = din[1];

    assign o_sel[0] = if0.sel;       assign o_sel[1] = if1.sel;
    assign o_out[0] = if0.ser_out;   assign o_out[1] = if1.ser_out;
    assign o_vld[0] = if0.ser_valid; assign o_vld[1] = if1.ser_valid;
    assign o_lst[0] = if0.ser_last;  assign o_lst[1] = if1.ser_last;
    assign o_rdy[0] = if0.load_ready; assign o_rdy[1] = if1.load_ready;

    mux_serializer_32bit #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u0 (
        .clk (clk), .rst (rst), .bus (if0.slave)
    );
    mux_serializer_32bit #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u1 (
        .clk (clk), .rst (rst), .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every wait in the bench is a fixed number of cycles. This guard only
    // catches a broken bench or a simulator stall.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    // Each vector lists the word, the instance, the expected emission order
    // (bit c of stream is the c-th bit on the wire) and the even parity.
    typedef struct {
        logic [31:0] word;
        int          m;
        logic [31:0] stream;
        logic        par;
        string       tag;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] start_of(input int m);
        return (m == 1) ? 5'd31 : 5'd0;
    endfunction

    function automatic logic idle_of(input int m);
        return (m == 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk_idle(input int m, input string tag);
        chk({tag, " ready"}, {31'd0, o_rdy[m]}, 32'd1);
        chk({tag, " valid"}, {31'd0, o_vld[m]}, 32'd0);
        chk({tag, " last"},  {31'd0, o_lst[m]}, 32'd0);
        chk({tag, " out"},   {31'd0, o_out[m]}, {31'd0, idle_of(m)});
        chk({tag, " sel"},   {27'd0, o_sel[m]}, {27'd0, start_of(m)});
    endtask

    // One check of a data bit cycle, sampled at the negedge.
    task automatic chk_bit(input int m, input int c, input logic [31:0] stream, input string tag);
        logic fin;
`ifdef PARITY_EN
        fin = 1'b0;
`else
        fin = (c == 31);
`endif
        chk($sformatf("%s c%0d valid", tag, c), {31'd0, o_vld[m]}, 32'd1);
        chk($sformatf("%s c%0d sel", tag, c), {27'd0, o_sel[m]},
            (m == 1) ? 32'(31 - c) : 32'(c));
        chk($sformatf("%s c%0d out", tag, c), {31'd0, o_out[m]}, {31'd0, stream[c]});
        chk($sformatf("%s c%0d last", tag, c), {31'd0, o_lst[m]}, {31'd0, fin});
        chk($sformatf("%s c%0d ready", tag, c), {31'd0, o_rdy[m]}, {31'd0, fin});
    endtask

    // Checks the whole frame, starting in the cycle right after the accepting edge.
    task automatic chk_frame(input int m, input logic [31:0] stream, input logic par, input string tag);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            chk_bit(m, c, stream, tag);
        end
`ifdef PARITY_EN
        @(negedge clk);
        chk({tag, " par valid"}, {31'd0, o_vld[m]}, 32'd1);
        chk({tag, " par out"},   {31'd0, o_out[m]}, {31'd0, par});
        chk({tag, " par last"},  {31'd0, o_lst[m]}, 32'd1);
        chk({tag, " par ready"}, {31'd0, o_rdy[m]}, 32'd1);
`else
        if (par === 1'bx) $display("note: parity unknown for %s", tag);
`endif
    endtask

    // Loads one word from IDLE and checks the frame and the return to IDLE.
    // data_in is corrupted after acceptance to show that the held copy is used.
    task automatic run_frame(input int m, input logic [31:0] word, input logic [31:0] stream,
                             input logic par, input string tag);
        @(posedge clk); #1;
        lv[m] = 1'b1; din[m] = word;
        @(posedge clk); #1;
        lv[m] = 1'b0; din[m] = ~word;
        chk_frame(m, stream, par, tag);
        @(negedge clk);
        chk_idle(m, {tag, " idle"});
    endtask

    initial begin
        vt[0] = '{32'hA5A5_0F0F, 0, 32'hA5A5_0F0F, 1'b0, "lsb_a5a5"};
        vt[1] = '{32'h8000_0001, 1, 32'h8000_0001, 1'b0, "msb_8001"};
        vt[2] = '{32'h0000_00F0, 1, 32'h0F00_0000, 1'b0, "msb_00f0"};
        vt[3] = '{32'h1234_5678, 0, 32'h1234_5678, 1'b1, "lsb_1234"};
        vt[4] = '{32'h0000_0007, 0, 32'h0000_0007, 1'b1, "lsb_0007"};
        vt[5] = '{32'h0000_0003, 1, 32'hC000_0000, 1'b0, "msb_0003"};

        rst = 1'b1;
        lv[0] = 1'b0; lv[1] = 1'b0;
        din[0] = '0;  din[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle(0, "reset u0");
        chk_idle(1, "reset u1");
        rst = 1'b0;
        @(negedge clk);
        chk_idle(0, "post reset u0");
        chk_idle(1, "post reset u1");

        for (int i = 0; i < 6; i++)
            run_frame(vt[i].m, vt[i].word, vt[i].stream, vt[i].par, vt[i].tag);

        // Back-to-back frames: load_valid stays high and the second word is
        // taken on the end-of-frame edge with no idle gap.
        @(posedge clk); #1;
        lv[0] = 1'b1; din[0] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        din[0] = 32'h0;
        chk_frame(0, 32'hFFFF_FFFF, 1'b0, "b2b_ones");
        @(posedge clk); #1;
        lv[0] = 1'b0;
        chk_frame(0, 32'h0, 1'b0, "b2b_zeros");
        @(negedge clk);
        chk_idle(0, "b2b idle");

        // Reset asserted at bit 10 of a frame acts immediately, without a clock edge.
        @(posedge clk); #1;
        lv[0] = 1'b1; din[0] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        lv[0] = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            chk_bit(0, c, 32'hDEAD_BEEF, "rst_mid");
        end
        rst = 1'b1;
        #1;
        chk_idle(0, "async rst u0");
        chk_idle(1, "async rst u1");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle(0, "after rst u0");
        run_frame(0, 32'h0000_0007, 32'h0000_0007, 1'b1, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
